chrono_control_fsm: RTL and testbench

Control unit for the start/stop chronometer with reset and lap. It debounces the two push-buttons and synchronises the divided timebase. It runs the chronometer state machine and drives the enable, clear and lap-capture strobes for the counter chain and the live/lap display multiplexer. It sits between the board buttons/frequency divider and the synchronous counters plus display mux.

---
 rtl/chrono_pkg.sv | 17 +
 rtl/chrono_button_debounce.sv | 58 +++++
 rtl/chrono_control_fsm.sv | 116 +++++++++++
 tb/tb_chrono_control_fsm.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/chrono_pkg.sv
// Shared definitions for the chronometer control slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package chrono_pkg;

  // Encodings are visible on the debug LEDs, so the values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,  // zeroed, stopped
    ST_RUNNING = 2'd1,  // counting, live display
    ST_LAP     = 2'd2,  // counting, display frozen on lap value
    ST_STOPPED = 2'd3   // paused, count held
  } chrono_state_t;

  // Width of the per-button stability counter.
  localparam int DEBOUNCE_CNT_W = 16;

endpackage

// File: rtl/chrono_button_debounce.sv
// Push-button conditioner: 2-flop synchroniser, debouncer, one-cycle press pulse.
// Latency: raw edge -> press pulse after DEBOUNCE_CYCLES+2 edges.
// Backpressure: none; press is a fire-and-forget strobe, release produces nothing.
//
// Ports:
//   clk_in, reset  : system clock, synchronous active-high reset
//   btn_raw        : raw bouncing button, asynchronous to clk_in
//   press          : registered one-cycle pulse on the debounced rising edge
module chrono_button_debounce
  import chrono_pkg::*;
#(
  parameter logic [DEBOUNCE_CNT_W-1:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk_in,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  logic                      sync_q1;
  logic                      sync_q2;
  logic                      db_level;
  logic                      db_prev;
  logic [DEBOUNCE_CNT_W-1:0] stable_cnt;
  logic                      cnt_reached;

  // Compare one bit wider so a DEBOUNCE_CYCLES of 0 behaves like 1 and the
  // increment cannot wrap.
  assign cnt_reached = ({1'b0, stable_cnt} + {{DEBOUNCE_CNT_W{1'b0}}, 1'b1})
                       >= {1'b0, DEBOUNCE_CYCLES};

  always_ff @(posedge clk_in) begin
    if (reset) begin
      sync_q1    <= 1'b0;
      sync_q2    <= 1'b0;
      db_level   <= 1'b0;
      db_prev    <= 1'b0;
      press      <= 1'b0;
      stable_cnt <= '0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
      db_prev <= db_level;
      press   <= db_level & ~db_prev;

      // Any sample matching the debounced level restarts the stability count.
      if (sync_q2 == db_level) begin
        stable_cnt <= '0;
      end else if (cnt_reached) begin
        db_level   <= sync_q2;
        stable_cnt <= '0;
      end else if (stable_cnt != {DEBOUNCE_CNT_W{1'b1}}) begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/chrono_control_fsm.sv
// Chronometer control: button conditioning, timebase edge detect, run/lap/stop FSM.
// Latency: button press -> state/strobes after DEBOUNCE_CYCLES+3 edges; tick_in rise -> count_tick after 3 edges.
// Backpressure: none; count_tick/count_clear/lap_latch are one-cycle strobes.
//
// Ports:
//   clk_in, reset                  : system clock, synchronous active-high reset
//   btn_start_stop, btn_lap_reset  : raw bouncing buttons
//   tick_in                        : divided timebase square wave (asynchronous)
//   count_tick                     : one pulse per tick_in rise while RUNNING or LAP
//   count_clear, lap_latch         : counter-chain clear and lap capture strobes
//   display_select                 : 0 live count, 1 frozen lap value
//   state                          : current FSM state for debug LEDs
module chrono_control_fsm
  import chrono_pkg::*;
#(
  parameter logic [DEBOUNCE_CNT_W-1:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       btn_start_stop,
  input  logic       btn_lap_reset,
  input  logic       tick_in,
  output logic       count_tick,
  output logic       count_clear,
  output logic       lap_latch,
  output logic       display_select,
  output logic [1:0] state
);

  logic          start_stop_press;
  logic          lap_reset_press;
  logic          tick_q1;
  logic          tick_q2;
  logic          tick_prev;
  logic          tick_pulse;
  chrono_state_t state_q;
  chrono_state_t state_d;
  logic          clear_d;
  logic          latch_d;

  chrono_button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start_stop (
    .clk_in  (clk_in),
    .reset   (reset),
    .btn_raw (btn_start_stop),
    .press   (start_stop_press)
  );

  chrono_button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap_reset (
    .clk_in  (clk_in),
    .reset   (reset),
    .btn_raw (btn_lap_reset),
    .press   (lap_reset_press)
  );

  always_ff @(posedge clk_in) begin
    if (reset) begin
      tick_q1     <= 1'b0;
      tick_q2     <= 1'b0;
      tick_prev   <= 1'b0;
      tick_pulse  <= 1'b0;
      count_tick  <= 1'b0;
      state_q     <= ST_IDLE;
      count_clear <= 1'b0;
      lap_latch   <= 1'b0;
    end else begin
      tick_q1    <= tick_in;
      tick_q2    <= tick_q1;
      tick_prev  <= tick_q2;
      tick_pulse <= tick_q2 & ~tick_prev;
      // Gate with the state held while the pulse is present, so a tick that
      // coincides with a state change is judged by the state it arrived in.
      count_tick  <= tick_pulse & ((state_q == ST_RUNNING) || (state_q == ST_LAP));
      state_q     <= state_d;
      count_clear <= clear_d;
      lap_latch   <= latch_d;
    end
  end

  // start_stop is tested first: on a simultaneous press the lap_reset event
  // is dropped rather than held over.
  always_comb begin
    state_d = state_q;
    clear_d = 1'b0;
    latch_d = 1'b0;
    if (start_stop_press) begin
      case (state_q)
        ST_IDLE:    state_d = ST_RUNNING;
        ST_RUNNING: state_d = ST_STOPPED;
        ST_LAP:     state_d = ST_STOPPED;
        ST_STOPPED: state_d = ST_RUNNING;
        default:    state_d = ST_IDLE;
      endcase
    end else if (lap_reset_press) begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
          clear_d = 1'b1;
        end
        ST_RUNNING: begin
          state_d = ST_LAP;
          latch_d = 1'b1;
        end
        ST_LAP:  state_d = ST_RUNNING;
        ST_STOPPED: begin
          state_d = ST_IDLE;
          clear_d = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign state          = state_q;
  assign display_select = (state_q == ST_LAP);

endmodule

// File: tb/tb_chrono_control_fsm.sv
// Self-checking bench for chrono_control_fsm with DEBOUNCE_CYCLES = 4.
// Directed scenarios followed by randomized button/tick/reset activity,
// all outputs compared every cycle against a history-window reference model.
module tb_chrono_control_fsm;

  localparam int D = 4;

  logic       clk_in = 1'b0;
  logic       reset = 1'b1;
  logic       btn_start_stop = 1'b0;
  logic       btn_lap_reset = 1'b0;
  logic       tick_in = 1'b0;
  logic       count_tick;
  logic       count_clear;
  logic       lap_latch;
  logic       display_select;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  chrono_control_fsm #(.DEBOUNCE_CYCLES(16'd4)) dut (
    .clk_in         (clk_in),
    .reset          (reset),
    .btn_start_stop (btn_start_stop),
    .btn_lap_reset  (btn_lap_reset),
    .tick_in        (tick_in),
    .count_tick     (count_tick),
    .count_clear    (count_clear),
    .lap_latch      (lap_latch),
    .display_select (display_select),
    .state          (state)
  );

  always #5 clk_in = ~clk_in;

  // ---------------- reference model ----------------
  // Histories are indexed by age in edges (0 = sampled at the latest edge)
  // and zero-filled on reset, which matches every register clearing.
  bit raw_h [2][0:2];    // raw button samples
  bit sync_h[2][0:D-1];  // synchronised level as seen by the debouncer
  bit db_h  [2][0:3];    // debounced level after each edge
  bit tk_h  [0:4];       // raw tick samples
  int m_state = 0;       // 0 idle, 1 running, 2 lap, 3 stopped
  bit e_tick, e_clr, e_lat;
  int ss_next[4] = '{1, 3, 3, 1};
  int lr_next[4] = '{0, 2, 1, 0};
  int tick_half = 3;
  int tick_cnt = 0;

  task automatic model_step(input bit r, input bit ss, input bit lr, input bit tk);
    bit raw[2];
    bit ev[2];
    bit all_diff;
    bit pulse;
    raw[0] = ss;
    raw[1] = lr;
    if (r) begin
      for (int b = 0; b < 2; b++) begin
        for (int j = 0; j < 3; j++) raw_h[b][j] = 1'b0;
        for (int j = 0; j < D; j++) sync_h[b][j] = 1'b0;
        for (int j = 0; j < 4; j++) db_h[b][j] = 1'b0;
      end
      for (int j = 0; j < 5; j++) tk_h[j] = 1'b0;
      m_state = 0;
      e_tick  = 1'b0;
      e_clr   = 1'b0;
      e_lat   = 1'b0;
      return;
    end
    for (int b = 0; b < 2; b++) begin
      for (int j = 2; j > 0; j--) raw_h[b][j] = raw_h[b][j-1];
      raw_h[b][0] = raw[b];
      // the debouncer sees the raw level from two edges ago
      for (int j = D - 1; j > 0; j--) sync_h[b][j] = sync_h[b][j-1];
      sync_h[b][0] = raw_h[b][2];
      // level flips when the last D samples all disagree with it
      all_diff = 1'b1;
      for (int j = 0; j < D; j++) if (sync_h[b][j] == db_h[b][0]) all_diff = 1'b0;
      for (int j = 3; j > 0; j--) db_h[b][j] = db_h[b][j-1];
      db_h[b][0] = all_diff ? ~db_h[b][1] : db_h[b][1];
      // debounced rise two edges back reaches the FSM now
      ev[b] = db_h[b][2] & ~db_h[b][3];
    end
    for (int j = 4; j > 0; j--) tk_h[j] = tk_h[j-1];
    tk_h[0] = tk;
    pulse  = tk_h[3] & ~tk_h[4];
    e_tick = pulse && (m_state == 1 || m_state == 2);
    e_clr  = 1'b0;
    e_lat  = 1'b0;
    if (ev[0]) begin
      m_state = ss_next[m_state];
    end else if (ev[1]) begin
      e_clr   = (m_state == 0 || m_state == 3);
      e_lat   = (m_state == 1);
      m_state = lr_next[m_state];
    end
  endtask

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input bit r, input bit ss, input bit lr);
    @(negedge clk_in);
    reset          = r;
    btn_start_stop = ss;
    btn_lap_reset  = lr;
    tick_cnt++;
    if (tick_cnt >= tick_half) begin
      tick_cnt = 0;
      tick_in  = ~tick_in;
    end
    @(posedge clk_in);
    model_step(r, ss, lr, tick_in);
    #1;
    check_val("state",          {6'd0, state},          8'(m_state));
    check_val("display_select", {7'd0, display_select}, {7'd0, (m_state == 2)});
    check_val("count_tick",     {7'd0, count_tick},     {7'd0, e_tick});
    check_val("count_clear",    {7'd0, count_clear},    {7'd0, e_clr});
    check_val("lap_latch",      {7'd0, lap_latch},      {7'd0, e_lat});
  endtask

  task automatic hold(input bit ss, input bit lr, input int n);
    repeat (n) cyc(1'b0, ss, lr);
  endtask

  // press and release one button cleanly
  task automatic tap(input bit ss, input bit lr);
    hold(ss, lr, 10);
    hold(1'b0, 1'b0, 10);
  endtask

  initial begin
    int dur;
    bit rs, ss, lr;

    // reset state
    repeat (3) cyc(1'b1, 1'b0, 1'b0);

    // clean start, ticks counted, then stop
    tap(1'b1, 1'b0);
    hold(1'b0, 1'b0, 20);
    tap(1'b1, 1'b0);
    hold(1'b0, 1'b0, 12);

    // bounce 1,0,1,1,0 then steady high: a single restart event
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    hold(1'b1, 1'b0, 12);
    hold(1'b0, 1'b0, 10);

    // lap in, lap out
    tap(1'b0, 1'b1);
    hold(1'b0, 1'b0, 6);
    tap(1'b0, 1'b1);

    // stop, clear, clear again in idle
    tap(1'b1, 1'b0);
    tap(1'b0, 1'b1);
    tap(1'b0, 1'b1);

    // start, then both buttons together, then lap_reset alone
    tap(1'b1, 1'b0);
    tap(1'b1, 1'b1);
    tap(1'b0, 1'b1);

    // reset in LAP with start_stop mid-debounce
    tap(1'b1, 1'b0);
    tap(1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    hold(1'b0, 1'b0, 15);

    // randomized activity
    for (int seg = 0; seg < 300; seg++) begin
      if ((seg % 25) == 0) tick_half = $urandom_range(1, 5);
      rs  = ($urandom_range(0, 39) == 0);
      ss  = ($urandom_range(0, 2) == 0);
      lr  = ($urandom_range(0, 2) == 0);
      dur = $urandom_range(1, 10);
      if (rs) cyc(1'b1, ss, lr);
      hold(ss, lr, dur);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
